// File: rtl/radar_pri_timer.sv
// PRI sequencer: steps TX -> SW -> RX -> WAIT once per pulse-repetition interval and
// drives the chirp generator, T/R switch and receive-window controls.
module radar_pri_timer #(
  parameter int unsigned CW = 16,
  parameter int unsigned DW = 8
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          enable_i,
  input  logic [CW-1:0] t_on_i,
  input  logic [CW-1:0] t_sw_i,
  input  logic [CW-1:0] t_look_i,
  input  logic [CW-1:0] t_reset_i,
  input  logic [DW-1:0] tx_div_i,
  output logic          tx_ena_o,
  output logic          tx_strobe_o,
  output logic          rx_ena_o,
  output logic          tr_sw_o,
  output logic          pulse_start_o,
  output logic [15:0]   pri_count_o,
  output logic          busy_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TX,
    S_SW,
    S_RX,
    S_WAIT
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] phase_q, phase_d;
  logic [CW-1:0] pri_cnt_q, pri_cnt_d;
  logic [DW-1:0] div_q, div_d;
  logic [CW-1:0] sh_sw_q, sh_look_q, sh_reset_q;
  logic [DW-1:0] sh_div_q;
  logic          start;

  always_comb begin
    state_d = state_q;
    if (!enable_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  state_d = S_TX;
        S_TX:    if (phase_q == '0) state_d = S_SW;
        S_SW:    if (phase_q == '0) state_d = S_RX;
        S_RX:    if (phase_q == '0) state_d = (pri_cnt_q >= sh_reset_q) ? S_TX : S_WAIT;
        S_WAIT:  if (pri_cnt_q >= sh_reset_q) state_d = S_TX;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // TX never re-enters itself, so any arrival in TX marks a new PRI.
  assign start = (state_d == S_TX) && (state_q != S_TX);

  always_comb begin
    phase_d   = phase_q;
    div_d     = div_q;
    pri_cnt_d = pri_cnt_q;
    if (state_d == S_IDLE) begin
      phase_d   = '0;
      div_d     = '0;
      pri_cnt_d = '0;
    end else if (start) begin
      phase_d   = t_on_i;
      div_d     = '0;
      pri_cnt_d = '0;
    end else begin
      pri_cnt_d = (pri_cnt_q == '1) ? pri_cnt_q : pri_cnt_q + CW'(1);
      if (state_d != state_q) begin
        phase_d = (state_d == S_SW) ? sh_sw_q : sh_look_q;
      end else begin
        phase_d = phase_q - CW'(1);
      end
      if (state_d == S_TX) begin
        div_d = (div_q == '0) ? sh_div_q : div_q - DW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= S_IDLE;
      phase_q    <= '0;
      pri_cnt_q  <= '0;
      div_q      <= '0;
      sh_sw_q    <= '0;
      sh_look_q  <= '0;
      sh_reset_q <= '0;
      sh_div_q   <= '0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      pri_cnt_q <= pri_cnt_d;
      div_q     <= div_d;
      if (start) begin
        sh_sw_q    <= t_sw_i;
        sh_look_q  <= t_look_i;
        sh_reset_q <= t_reset_i;
        sh_div_q   <= tx_div_i;
      end
    end
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tx_ena_o      <= 1'b0;
      tx_strobe_o   <= 1'b0;
      rx_ena_o      <= 1'b0;
      tr_sw_o       <= 1'b0;
      pulse_start_o <= 1'b0;
      busy_o        <= 1'b0;
      pri_count_o   <= '0;
    end else begin
      tx_ena_o      <= (state_d == S_TX);
      tx_strobe_o   <= (state_d == S_TX) && (div_d == '0);
      rx_ena_o      <= (state_d == S_RX);
      tr_sw_o       <= (state_d == S_TX) || (state_d == S_SW);
      pulse_start_o <= start;
      busy_o        <= (state_d != S_IDLE);
      if (start) pri_count_o <= pri_count_o + 16'd1;
    end
  end

endmodule

// File: doc/radar_pri_timer.md
Name: radar_pri_timer

Overview:
- Pulse-repetition-interval (PRI) sequencer for the monostatic radar transmit/receive chain.
- Sits directly upstream of the chirp generator. Drives its enable and sample strobe, so each transmit pulse restarts the chirp from its start frequency.
- Also produces the receive-window enable, a transmit/receive switch control and per-pulse markers for the receive path.
- Timing configuration is captured into shadow registers at each PRI start, so host writes never corrupt a pulse in progress.

Parameters:
- CW, 16, width of all timing count fields and of the PRI counter.
- DW, 8, width of the transmit strobe divider.

Ports:
- clk_i in 1: system clock, all logic on rising edge.
- rst_n_i in 1: asynchronous active-low reset.
- enable_i in 1: run request; low forces IDLE.
- t_on_i in CW: transmit length minus 1, in clocks.
- t_sw_i in CW: TX-to-RX switch guard minus 1, in clocks.
- t_look_i in CW: receive window minus 1, in clocks.
- t_reset_i in CW: nominal PRI minus 1, in clocks.
- tx_div_i in DW: transmit strobe period minus 1.
- tx_ena_o out 1: chirp generator enable.
- tx_strobe_o out 1: chirp generator sample strobe.
- rx_ena_o out 1: receive window active.
- tr_sw_o out 1: T/R switch control; 1 = transmit path, high in TX and SW.
- pulse_start_o out 1: one-clock pulse on the first TX cycle of each PRI.
- pri_count_o out 16: count of started PRIs, wraps at 0xFFFF to 0.
- busy_o out 1: state is not IDLE.

Behaviour:
- Reset (async, rst_n_i low):
  - State = IDLE.
  - All outputs 0, pri_count_o = 0.
  - Shadow registers and counters = 0.
  - Deassertion is sampled synchronously; the first active edge after release behaves as IDLE.
- Outputs: all registered and decoded from the next-state, so each output is valid in the same cycle its state is occupied.
- States: IDLE, TX, SW, RX, WAIT.
- IDLE:
  - Move to TX when enable_i is sampled high.
  - tx_ena_o rises on the edge after the sampling edge, i.e. 1 cycle latency.
- PRI start (every entry to TX):
  - Latch t_on/t_sw/t_look/t_reset/tx_div into shadow registers.
  - pri_cnt = 0, phase counter = shadow t_on, divider counter = 0.
  - pulse_start_o = 1 for that cycle; pri_count_o increments by 1, wrapping.
- TX:
  - tx_ena_o = 1, tr_sw_o = 1.
  - tx_strobe_o = 1 whenever the divider counter is 0; the counter then reloads shadow tx_div, otherwise it decrements. The first TX cycle therefore always strobes.
  - Exit to SW when the phase counter is 0; load t_sw.
- SW: all outputs 0 except tr_sw_o = 1. Exit to RX when the phase counter is 0; load t_look.
- RX: rx_ena_o = 1, tr_sw_o = 0. On the last RX cycle:
  - if pri_cnt >= shadow t_reset, go to TX (new PRI);
  - otherwise go to WAIT.
- WAIT: all enables 0. Go to TX on the cycle after pri_cnt == shadow t_reset.
- pri_cnt:
  - Increments every non-IDLE cycle and saturates at all-ones.
  - Effective PRI = max(t_reset+1, t_on+t_sw+t_look+3) clocks (overrun stretches the PRI; it is never truncated).
- Phase counter: each phase lasts field+1 cycles; field = 0 gives exactly 1 cycle.
- enable_i low in any non-IDLE state:
  - Next state is IDLE; all outputs 0 on the following edge.
  - In-progress pulse aborted; pri_count_o retained.
- enable_i held high: PRIs repeat back-to-back with no IDLE cycle.
- Config input changes mid-PRI have no effect until the next PRI start.
- tx_strobe_o is never high outside TX.
- Mutual exclusion: tx_ena_o and rx_ena_o are never both high.

Test Plan:
- t_on=3, t_sw=1, t_look=4, t_reset=19, tx_div=1, enable rising at cycle 0 -> expected response:
  - tx_ena cycles 1-4, strobes cycles 1 and 3;
  - tr_sw cycles 1-6, rx_ena cycles 7-11;
  - next pulse_start at cycle 21; pri_count_o = 1 then 2.
- Same config with t_reset=5 -> PRI stretches to 11 clocks; RX last cycle goes straight to TX with no WAIT; pulse_start every 11 cycles.
- tx_div=0, t_on=2 -> tx_strobe_o high on all 3 TX cycles; t_sw=t_look=0 -> SW and RX last 1 cycle each.
- Change t_on from 3 to 7 during RX -> current PRI unchanged; the following TX lasts 8 cycles.
- enable_i dropped during TX cycle 2 -> all outputs 0 on next edge, busy_o=0, pri_count_o held; re-enable -> fresh PRI with strobe on first TX cycle.
- Assert rst_n_i low mid-RX, asynchronously between edges -> outputs and pri_count_o 0 immediately without a clock edge; after release, IDLE until enable_i is sampled high.
